ifu_fetch: RTL

Instruction fetch unit for the NPC core, sitting directly upstream of the instruction ROM and downstream-feeding the decode stage. It owns the program counter, drives the ROM address, and captures each returned word with its PC in a small FIFO. Decode drains the FIFO through a valid/ready handshake. Branch/jump redirects flush the FIFO and reload the PC.

---
 rtl/ifu_fetch_if.sv | 55 +++++
 rtl/ifu_fetch.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch_if
//  Description : Bundle of the ROM address/data path, the redirect request
//                and the decode-side valid/ready handshake of the
//                instruction fetch unit.
//                master : fetch-unit side (drives inst_addr and out_*)
//                slave  : environment side (ROM, execute, decode)
//  Signals     : inst_addr[31:0]   ROM address (combinationally the PC)
//                inst_data[31:0]   ROM word for inst_addr, same cycle
//                redirect_valid    redirect request from execute
//                redirect_pc[31:0] redirect target (bits [1:0] ignored)
//                out_valid         FIFO head holds a fetched instruction
//                out_ready         decode accepts the head this cycle
//                out_pc[31:0]      PC of the head entry
//                out_inst[31:0]    instruction word of the head entry
//                out_err           head entry fetched outside the ROM window
//  Revision    : 1.0  initial release
// ============================================================================
interface ifu_fetch_if;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;

    modport master (
        output inst_addr,
        input  inst_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        output out_err
    );

    modport slave (
        input  inst_addr,
        output inst_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        input  out_err
    );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction fetch unit. Owns the program counter, drives the
//                combinational ROM address, and captures each returned word
//                together with its PC and a range-error flag in a small FIFO
//                drained by decode through a valid/ready handshake. A
//                redirect flushes the FIFO and reloads the PC.
//  Ports       : clk   rising-edge clock
//                rst   synchronous active-high reset
//                bus   ifu_fetch_if.master (ROM, redirect, decode handshake)
//  Parameters  : RESET_PC   PC after reset and base of the ROM window
//                ROM_WORDS  number of 32-bit words in the ROM window
//                DEPTH      FIFO entries (2 or 4)
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned ROM_WORDS = 32,
    parameter int unsigned DEPTH     = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ifu_fetch_if.master bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Window bounds held in 33 bits so RESET_PC + 4*ROM_WORDS cannot wrap
    // and the unsigned compare stays exact at the top of the address space.
    localparam logic [32:0] ROM_BASE = {1'b0, RESET_PC};
    localparam logic [32:0] ROM_END  = {1'b0, RESET_PC} + 33'(4 * ROM_WORDS);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]      pc_q,     pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic [31:0] slot_pc_q   [DEPTH];
    logic [31:0] slot_inst_q [DEPTH];
    logic        slot_err_q  [DEPTH];

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------
    logic pop;
    logic fetch;
    logic fetch_err;

    // Bits [1:0] of the redirect target are architecturally ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        pop       = (count_q != '0) & bus.out_ready;
        // A full FIFO may still fetch when the head leaves in the same
        // cycle: the write slot is then the slot being vacated.
        fetch     = ~bus.redirect_valid & ((count_q < CNT_FULL) | pop);
        fetch_err = ({1'b0, pc_q} < ROM_BASE) | ({1'b0, pc_q} >= ROM_END);
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.redirect_valid) begin
            // A same-cycle pop is still seen by decode; whatever it left
            // behind is discarded together with the rest of the FIFO.
            pc_d     = {bus.redirect_pc[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fetch) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (fetch && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !fetch) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // One storage slot per FIFO entry, written only when it is the write
    // target of a fetch. Slots are cleared on reset so the empty-FIFO
    // outputs read as zero immediately afterwards.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst) begin
                slot_pc_q[i]   <= '0;
                slot_inst_q[i] <= '0;
                slot_err_q[i]  <= 1'b0;
            end else if (fetch && (wr_ptr_q == PTR_W'(i))) begin
                slot_pc_q[i]   <= pc_q;
                slot_inst_q[i] <= bus.inst_data;
                slot_err_q[i]  <= fetch_err;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.inst_addr = pc_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = slot_pc_q[rd_ptr_q];
    assign bus.out_inst  = slot_inst_q[rd_ptr_q];
    assign bus.out_err   = slot_err_q[rd_ptr_q];

endmodule
`default_nettype wire
